// File: rtl/ddr_frame_rd_sched.sv
// Read-side DDR frame scheduler: arms a frame read, then paces
// FIFO pops into fixed-size sop/eop-framed packets with gaps.
module ddr_frame_rd_sched #(
  parameter int DATA_WD     = 16,
  parameter int FRAME_WORDS = 518400,
  parameter int PKT_WORDS   = 720,
  parameter int LOAD_HOLD   = 8,
  parameter int GAP_CYCLES  = 16
) (
  input  logic               rd_clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               frame_done,
  output logic               rd_load,
  output logic               rd_en,
  input  logic               rd_rdy,
  input  logic [DATA_WD-1:0] rd_data,
  input  logic               rd_valid,
  input  logic               pkt_ready,
  output logic [DATA_WD-1:0] m_data,
  output logic               m_valid,
  output logic               m_sop,
  output logic               m_eop
);

  localparam int CW   = $clog2(FRAME_WORDS + 1);
  localparam int TMAX = (LOAD_HOLD > GAP_CYCLES) ? LOAD_HOLD : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] FRAME_N = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] PKT_N   = CW'(PKT_WORDS);

  typedef enum logic [2:0] {
    IDLE, LOAD_HI, LOAD_LO, WAIT_PKT,
    BURST, DRAIN, GAP, DONE
  } state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tmr;
  logic [CW-1:0]   words_left;
  logic [CW-1:0]   issue_left;
  logic [CW-1:0]   pkt_len;
  logic [CW-1:0]   out_cnt;
  logic [CW-1:0]   next_len;
  logic [2:0]      pend;
  logic [1:0]      kill;
  logic            acc;
  logic            rd_ret;

  assign next_len = (words_left < PKT_N) ? words_left : PKT_N;
  assign rd_ret   = rd_valid && (pend != 3'd0);
  assign acc      = rd_ret && (kill == 2'd0) && !abort;

  // State register and per-state cycle timer
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nx;
      tmr   <= (state_nx != state) ? '0 : tmr + 1'b1;
    end
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_nx = state;
    rd_load  = 1'b0;
    rd_en    = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:     if (start) state_nx = LOAD_HI;
      LOAD_HI: begin
        rd_load = 1'b1;
        if (tmr == TW'(LOAD_HOLD - 1)) state_nx = LOAD_LO;
      end
      LOAD_LO:
        if (tmr == TW'(LOAD_HOLD - 1)) state_nx = WAIT_PKT;
      WAIT_PKT:
        if (pkt_ready && rd_rdy) state_nx = BURST;
      BURST: begin
        rd_en = rd_rdy && !abort;
        if (rd_en && issue_left == CW'(1)) state_nx = DRAIN;
      end
      DRAIN:
        if (tmr == TW'(1))
          state_nx = (words_left != '0) ? GAP : DONE;
      GAP:
        if (tmr == TW'(GAP_CYCLES - 1)) state_nx = WAIT_PKT;
      DONE:     state_nx = IDLE;
    endcase
    if (abort) state_nx = IDLE;
  end

  // Frame and packet issue counters
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      words_left <= '0;
      issue_left <= '0;
      pkt_len    <= '0;
    end else if (abort) begin
      words_left <= '0;
      issue_left <= '0;
    end else if (state == IDLE && start) begin
      words_left <= FRAME_N;
    end else if (state == WAIT_PKT && state_nx == BURST) begin
      pkt_len    <= next_len;
      issue_left <= next_len;
    end else if (rd_en) begin
      issue_left <= issue_left - 1'b1;
      if (words_left != '0) words_left <= words_left - 1'b1;
    end
  end

  // Outstanding-read tracking and post-abort discard window
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
      kill <= '0;
    end else if (abort) begin
      pend <= '0;
      kill <= 2'd2;
    end else begin
      pend <= pend + {2'b0, rd_en} - {2'b0, rd_ret};
      if (kill != 2'd0) kill <= kill - 1'b1;
    end
  end

  // Registered output stage with sop/eop framing
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_data     <= '0;
      m_valid    <= 1'b0;
      m_sop      <= 1'b0;
      m_eop      <= 1'b0;
      out_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      m_valid    <= acc;
      m_sop      <= acc && (out_cnt == '0);
      m_eop      <= acc && (out_cnt == pkt_len - 1'b1);
      frame_done <= (state == DONE) && !abort;
      if (abort)
        out_cnt <= '0;
      else if (acc) begin
        m_data  <= rd_data;
        out_cnt <= (out_cnt == pkt_len - 1'b1) ? '0 : out_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ddr_frame_rd_sched.sv
// Randomized bench for ddr_frame_rd_sched against a packet-stream
// reference model, plus a second instance with an exact-multiple frame.
module tb_ddr_frame_rd_sched;

  localparam int DW = 16;
  localparam int FW = 10;
  localparam int PW = 4;
  localparam int LH = 4;
  localparam int GC = 3;

  logic          rd_clk = 1'b0;
  logic          rst_n  = 1'b0;
  logic          start  = 1'b0;
  logic          abort  = 1'b0;
  logic          rd_rdy = 1'b1;
  logic          pkt_ready = 1'b1;
  logic          inj    = 1'b0;
  logic          busy, frame_done, rd_load, rd_en;
  logic          m_valid, m_sop, m_eop;
  logic [DW-1:0] m_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;

  logic [1:0]    vp = '0;
  logic [DW-1:0] dp0 = '0, dp1 = '0;
  logic [DW-1:0] seq = '0;

  logic          start8 = 1'b0;
  logic          abort8 = 1'b0;
  logic [DW-1:0] zdata  = '0;
  logic          busy8, done8, load8, rden8;
  logic          mv8, sop8, eop8;
  logic [DW-1:0] md8;
  logic [1:0]    vp8 = '0;

  int errs = 0;
  int checks = 0;

  int cyc = 0, w = 0, n_rden = 0, n_done = 0;
  int n_sop = 0, n_eop = 0, last_rd = -1, min_gap = 1000;
  logic [DW-1:0] base = '0;
  int n8w = 0, n8e = 0, n8s = 0, n8d = 0, n8r = 0;

  always #5 rd_clk = ~rd_clk;

  ddr_frame_rd_sched #(
    .DATA_WD(DW), .FRAME_WORDS(FW), .PKT_WORDS(PW),
    .LOAD_HOLD(LH), .GAP_CYCLES(GC)
  ) u_dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .start(start), .abort(abort),
    .busy(busy), .frame_done(frame_done), .rd_load(rd_load),
    .rd_en(rd_en), .rd_rdy(rd_rdy), .rd_data(rd_data),
    .rd_valid(rd_valid), .pkt_ready(pkt_ready), .m_data(m_data),
    .m_valid(m_valid), .m_sop(m_sop), .m_eop(m_eop)
  );

  ddr_frame_rd_sched #(
    .DATA_WD(DW), .FRAME_WORDS(8), .PKT_WORDS(PW),
    .LOAD_HOLD(LH), .GAP_CYCLES(GC)
  ) u_dut8 (
    .rd_clk(rd_clk), .rst_n(rst_n), .start(start8), .abort(abort8),
    .busy(busy8), .frame_done(done8), .rd_load(load8),
    .rd_en(rden8), .rd_rdy(rd_rdy), .rd_data(zdata),
    .rd_valid(vp8[1]), .pkt_ready(pkt_ready), .m_data(md8),
    .m_valid(mv8), .m_sop(sop8), .m_eop(eop8)
  );

  // FIFO model: data/valid appear two cycles after each pop
  always @(posedge rd_clk) begin
    vp  <= {vp[0], rd_en};
    dp0 <= seq;
    dp1 <= dp0;
    if (rd_en) seq <= seq + 1'b1;
    vp8 <= {vp8[0], rden8};
  end
  assign rd_valid = vp[1] | inj;
  assign rd_data  = dp1;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rd_clk);
    #1;
  endtask

  task automatic start_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    chk(tag, busy, 0);
    repeat (3) tick();
  endtask

  task automatic wait_rden(input string tag);
    int n = 0;
    @(negedge rd_clk);
    while (!rd_en && n < 60) begin
      @(negedge rd_clk);
      n++;
    end
    chk(tag, rd_en, 1);
  endtask

  task automatic chk_frame(input string tag);
    chk({tag, "_words"}, w, FW);
    chk({tag, "_rden"}, n_rden, FW);
    chk({tag, "_sop"}, n_sop, 3);
    chk({tag, "_eop"}, n_eop, 3);
    chk({tag, "_done"}, n_done, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {busy, frame_done, rd_load, rd_en,
              m_valid, m_sop, m_eop, m_data}, 0);
  endtask

  // Reference model: every output word is checked against the frame
  // position it must carry; packets are PW words, last one the remainder
  initial forever begin
    int pos, pst, len;
    @(negedge rd_clk);
    cyc++;
    if (start && !busy && !abort && rst_n) begin
      w = 0; n_rden = 0; n_done = 0; n_sop = 0; n_eop = 0;
      last_rd = -1; min_gap = 1000; base = seq;
    end
    if (rd_en) begin
      chk("rden_rdy", rd_rdy, 1);
      if (last_rd >= 0 && cyc - last_rd > 1 &&
          cyc - last_rd - 1 < min_gap)
        min_gap = cyc - last_rd - 1;
      last_rd = cyc;
      n_rden++;
    end
    if (m_valid) begin
      pos = w % PW;
      pst = w - pos;
      len = (FW - pst < PW) ? FW - pst : PW;
      chk("data", m_data, DW'(base + DW'(w)));
      chk("sop", m_sop, pos == 0);
      chk("eop", m_eop, pos == len - 1);
      n_sop += int'(m_sop);
      n_eop += int'(m_eop);
      w++;
    end
    if (frame_done) begin
      n_done++;
      chk("done_at_end", w, FW);
    end
    if (mv8) n8w++;
    if (mv8 && sop8) n8s++;
    if (mv8 && eop8) begin
      n8e++;
      chk("f8_eop_pos", n8w % PW, 0);
    end
    if (done8) n8d++;
    if (rden8) n8r++;
  end

  initial begin
    int n;
    bit got;
    #1;
    chk_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: nominal frame, rd_load pulse shape and packet framing
    start_frame();
    for (int i = 0; i < 2 * LH; i++) begin
      @(negedge rd_clk);
      chk("rd_load", rd_load, i < LH);
    end
    wait_idle("t1_idle", 200);
    chk_frame("t1");
    chk("t1_gap", min_gap >= GC, 1);

    // stray rd_valid with no outstanding read
    inj = 1'b1;
    tick();
    inj = 1'b0;
    repeat (2) begin
      @(negedge rd_clk);
      chk("stray_valid", m_valid, 0);
    end
    tick();

    // 2: sink not ready holds off all reads
    pkt_ready = 1'b0;
    start_frame();
    repeat (20) tick();
    chk("t2_hold", n_rden, 0);
    pkt_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge rd_clk);
      if (rd_en) got = 1'b1;
    end
    chk("t2_latency", got, 1);
    wait_idle("t2_idle", 200);
    chk_frame("t2");

    // 3: FIFO not ready mid-packet pauses rd_en only
    start_frame();
    wait_rden("t3_first");
    tick();
    rd_rdy = 1'b0;
    repeat (3) begin
      @(negedge rd_clk);
      chk("t3_pause", rd_en, 0);
      tick();
    end
    rd_rdy = 1'b1;
    @(negedge rd_clk);
    chk("t3_resume", rd_en, 1);
    wait_idle("t3_idle", 200);
    chk_frame("t3");

    // 4a: start while busy is ignored
    start_frame();
    wait_rden("t4_first");
    tick();
    start_frame();
    wait_idle("t4a_idle", 200);
    chk_frame("t4a");

    // 4b: abort mid-burst
    start_frame();
    wait_rden("t4b_first");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge rd_clk);
    chk("t4b_rden", rd_en, 0);
    chk("t4b_busy", busy, 0);
    repeat (4) begin
      chk("t4b_mvalid", m_valid, 0);
      @(negedge rd_clk);
    end
    repeat (20) tick();
    chk("t4b_nodone", n_done, 0);

    // randomized backpressure with stray start pulses
    for (int f = 0; f < 5; f++) begin
      start_frame();
      n = 0;
      while (busy && n < 3000) begin
        rd_rdy    = $urandom_range(0, 3) != 0;
        pkt_ready = $urandom_range(0, 2) != 0;
        start     = $urandom_range(0, 7) == 0;
        tick();
        n++;
      end
      start = 1'b0;
      rd_rdy = 1'b1;
      pkt_ready = 1'b1;
      chk("rand_idle", busy, 0);
      repeat (3) tick();
      chk_frame("rand");
    end

    // 6: reset asserted mid-gap
    start_frame();
    n = 0;
    while (n_eop == 0 && n < 200) begin
      @(negedge rd_clk);
      n++;
    end
    chk("t6_eop_seen", n_eop, 1);
    @(posedge rd_clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("t6_async");
    tick();
    chk_zero("t6_held");
    rst_n = 1'b1;
    repeat (4) tick();
    start_frame();
    wait_idle("t6_idle", 200);
    chk_frame("t6");

    // 5: exact-multiple frame on the 8-word instance
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    n = 0;
    while (busy8 && n < 300) begin
      tick();
      n++;
    end
    chk("t5_idle", busy8, 0);
    repeat (3) tick();
    chk("t5_words", n8w, 8);
    chk("t5_rden", n8r, 8);
    chk("t5_sop", n8s, 2);
    chk("t5_eop", n8e, 2);
    chk("t5_done", n8d, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
